// File: rtl/hsid_mse_sequencer.sv
// Control FSM for the hyperspectral MSE search. For each library pixel it
// streams band addresses to the captured-pixel and library buffers, qualifies
// the returning data into the MSE unit, then keeps the lowest MSE result.
// Best index and best MSE are reported when the whole library has been scanned.
module hsid_mse_sequencer #(
  parameter int BANDS_WIDTH    = 7,
  parameter int LIBRARY_WIDTH  = 6,
  parameter int DATA_WIDTH_ACC = 40
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 start,
  input  logic [BANDS_WIDTH-1:0]               cfg_bands,
  input  logic [LIBRARY_WIDTH-1:0]             cfg_lib_size,
  output logic                                 cap_rd_en,
  output logic [BANDS_WIDTH-1:0]               cap_rd_addr,
  output logic                                 lib_rd_en,
  output logic [BANDS_WIDTH+LIBRARY_WIDTH-1:0] lib_rd_addr,
  output logic                                 mse_clear,
  output logic                                 mse_band_valid,
  output logic                                 mse_last_band,
  input  logic                                 mse_valid,
  input  logic [DATA_WIDTH_ACC-1:0]            mse_value,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [LIBRARY_WIDTH-1:0]             best_index,
  output logic [DATA_WIDTH_ACC-1:0]            best_mse
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONFIG  = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
  localparam logic [2:0] S_CLEAR   = 3'd7;

  logic [2:0]                state;
  logic [BANDS_WIDTH-1:0]    b_q, band;
  logic [LIBRARY_WIDTH-1:0]  n_q, pixel;
  logic [DATA_WIDTH_ACC-1:0] mse_q;
  logic                      issuing, last_issue;

  assign issuing    = (state == S_COMPUTE);
  assign last_issue = issuing && (band == b_q - BANDS_WIDTH'(1));

  // Issue-side outputs are pure decodes of state; addresses stay quiet when idle.
  always_comb begin
    cap_rd_en   = issuing;
    lib_rd_en   = issuing;
    cap_rd_addr = issuing ? band : '0;
    lib_rd_addr = issuing ? {pixel, band} : '0;
    mse_clear   = issuing && (band == '0);
    done        = (state == S_DONE);
    error       = (state == S_ERROR);
    busy        = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
  end

  // Buffer data arrives one cycle after the read; clear abandons reads in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mse_band_valid <= 1'b0;
      mse_last_band  <= 1'b0;
    end else begin
      mse_band_valid <= issuing & ~clear;
      mse_last_band  <= last_issue & ~clear;
    end
  end

  // Main sequencing FSM with band/pixel counters and best-match tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      b_q        <= '0;
      n_q        <= '0;
      band       <= '0;
      pixel      <= '0;
      mse_q      <= '0;
      best_index <= '0;
      best_mse   <= '0;
    end else if (clear) begin
      // Zero everything on entry so the CLEAR cycle already shows clean results.
      state      <= S_CLEAR;
      b_q        <= '0;
      n_q        <= '0;
      band       <= '0;
      pixel      <= '0;
      mse_q      <= '0;
      best_index <= '0;
      best_mse   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_CONFIG;
        S_CONFIG: begin
          b_q   <= cfg_bands;
          n_q   <= cfg_lib_size;
          band  <= '0;
          pixel <= '0;
          state <= (cfg_bands == '0 || cfg_lib_size == '0) ? S_ERROR : S_COMPUTE;
        end
        S_COMPUTE: begin
          band <= band + BANDS_WIDTH'(1);
          if (last_issue) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mse_valid) begin
            mse_q <= mse_value;
            state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          // Strict compare: on ties the earlier (lower) index is kept.
          if (pixel == '0 || mse_q < best_mse) begin
            best_mse   <= mse_q;
            best_index <= pixel;
          end
          if (pixel == n_q - LIBRARY_WIDTH'(1)) begin
            state <= S_DONE;
          end else begin
            pixel <= pixel + LIBRARY_WIDTH'(1);
            band  <= '0;
            state <= S_COMPUTE;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_ERROR;
        S_CLEAR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hsid_mse_sequencer.md
Name: hsid_mse_sequencer

Overview:
- Control FSM that sequences the MSE datapath over a hyperspectral library.
- Per library pixel, streams band addresses to the captured-pixel and library buffers and qualifies band data into the MSE unit.
- Collects each MSE result and tracks the minimum.
- Reports the best-matching library index and its MSE to the top level.

Parameters:
- BANDS_WIDTH, 7, bits of band index/count (up to 127 bands).
- LIBRARY_WIDTH, 6, bits of library pixel index/count (up to 63 pixels).
- DATA_WIDTH_ACC, 40, MSE result width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear request, accepted in any state.
- start  in  1  start request, accepted only in IDLE.
- cfg_bands  in  BANDS_WIDTH  bands per pixel, B.
- cfg_lib_size  in  LIBRARY_WIDTH  library pixels, N.
- cap_rd_en  out  1  captured-buffer read strobe.
- cap_rd_addr  out  BANDS_WIDTH  captured band address.
- lib_rd_en  out  1  library-buffer read strobe.
- lib_rd_addr  out  BANDS_WIDTH+LIBRARY_WIDTH  {pixel index, band}.
- mse_clear  out  1  reset MSE accumulator.
- mse_band_valid  out  1  buffer data valid for the MSE unit this cycle.
- mse_last_band  out  1  qualifies final band of a pixel.
- mse_valid  in  1  MSE result strobe.
- mse_value  in  DATA_WIDTH_ACC  MSE result.
- busy  out  1  state not IDLE/DONE/ERROR.
- done  out  1  one-cycle completion pulse.
- error  out  1  high while in ERROR.
- best_index  out  LIBRARY_WIDTH  index of minimum MSE.
- best_mse  out  DATA_WIDTH_ACC  minimum MSE.

Behaviour:
- Reset: all outputs 0; state IDLE; internal band/pixel counters 0.
- Buffers have 1-cycle read latency.
  - mse_band_valid equals rd_en delayed one cycle.
  - mse_last_band equals the delayed last-issue flag.
- States and transitions:
  - IDLE: start goes to CONFIG.
  - CONFIG: latch B and N.
    - If B==0 or N==0, go to ERROR.
    - Otherwise, pixel=0, band=0, go to COMPUTE_MSE.
  - COMPUTE_MSE:
    - Each cycle: cap_rd_en=lib_rd_en=1, cap_rd_addr=band, lib_rd_addr={pixel,band}, band++.
    - mse_clear=1 on the first issue cycle of each pixel.
    - After issuing band B-1, go to WAIT_MSE.
  - WAIT_MSE: hold until mse_valid. Then latch mse_value and go to COMPARE_MSE.
  - COMPARE_MSE:
    - If pixel==0 or value < best_mse (strict, unsigned), update best_mse/best_index. Ties keep the lower index.
    - If pixel==N-1, go to DONE. Otherwise pixel++, band=0, go to COMPUTE_MSE.
  - DONE: done=1 for one cycle, then IDLE.
  - ERROR: error=1; stays until clear.
  - CLEAR: one cycle; zero best_*, counters, and latched config; then IDLE.
- clear in any state forces CLEAR next cycle and overrides start. Outstanding reads are abandoned; mse_band_valid drops the cycle after.
- start outside IDLE is ignored; cfg_* are sampled only in CONFIG.
- mse_valid outside WAIT_MSE is ignored.
- best_index and best_mse hold after DONE until the next start's first compare, clear, or reset.
- Per-pixel cycles: B issue + ≥1 wait + 1 compare. An MSE unit with latency L after the last band gives B+L+1.
- Async reset mid-operation returns to IDLE immediately with all outputs 0.

Test Plan:
- B=4, N=3, MSE unit returns 50, 20, 30:
  - lib_rd_addr sequence {0,0..3}, {1,0..3}, {2,0..3}.
  - mse_clear once per pixel.
  - done pulses once; best_index=1, best_mse=20.
- B=1, N=1, MSE=0x_FF_FFFF_FFFF: one issue cycle with mse_last_band high the next cycle; best_index=0, best_mse=0xFFFFFFFFFF.
- Ties with N=3, MSE 7, 7, 7: best_index=0, best_mse=7.
- cfg_bands=0 or cfg_lib_size=0 with start:
  - ERROR, error=1, no rd_en; start ignored.
  - clear then returns to IDLE with error=0.
- clear asserted during COMPUTE_MSE of pixel 2 (N=5): next cycle CLEAR, rd_en=0, best_*=0, then IDLE; a following start runs cleanly from pixel 0.
- rst_n low during WAIT_MSE, with late mse_valid after reset release: outputs 0, state IDLE, mse_valid ignored, done never pulses.
